// File: rtl/fft_pkg.sv
// Constants shared by the MDC FFT stage controllers, delay lines and twiddle ROM.
package fft_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int N     = 32;
    localparam int FRAME = N / 2;
    localparam int CW    = clog2(FRAME);

endpackage

// File: rtl/mdc_stage_ctrl.sv
// Sequencing for one radix-2 MDC stage: input framing, commutator select,
// delay-line output window, butterfly enable and twiddle addressing.
//
// state   | meaning
// IDLE    | waiting for in_valid & in_sop, cnt = 0
// FRAME   | frame in progress, cnt = index of the sample at the input
module mdc_stage_ctrl
    import fft_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sop,
    output logic          sw_sel,
    output logic          out_valid,
    output logic          out_sop,
    output logic          out_last,
    output logic          bf_en,
    output logic [CW-1:0] tw_addr,
    output logic          err_gap,
    output logic          busy
);

    localparam logic [0:0]    S_IDLE   = 1'b0;
    localparam logic [0:0]    S_FRAME  = 1'b1;
    localparam int            TW_STEP  = FRAME / DEPTH;
    localparam logic [CW-1:0] LAST     = CW'(FRAME - 1);
    localparam logic [CW-1:0] TMR_LOAD = CW'(DEPTH - 1);
    localparam bit            DIRECT   = (DEPTH == 1);

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          err_q;
    logic [CW-1:0] tmr;
    logic          tmr_run;
    logic          ov_q;
    logic [CW-1:0] ocnt;

    logic sop_acc;
    logic frm_err;
    logic win_start;

    assign sop_acc = (state == S_IDLE) && in_valid && in_sop;
    assign frm_err = (state == S_FRAME) && (!in_valid || in_sop);
    // A one-deep delay line puts sample 0 at the output right after the sop edge.
    assign win_start = DIRECT ? sop_acc : (tmr_run && (tmr == CW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= frm_err;
            case (state)
                S_IDLE: begin
                    if (sop_acc) begin
                        state <= S_FRAME;
                        cnt   <= CW'(1);
                    end
                end
                default: begin
                    if (frm_err || cnt == LAST) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr     <= '0;
            tmr_run <= 1'b0;
        end else if (frm_err) begin
            tmr     <= '0;
            tmr_run <= 1'b0;
        end else if (sop_acc && !DIRECT) begin
            tmr     <= TMR_LOAD;
            tmr_run <= 1'b1;
        end else if (tmr_run) begin
            if (tmr == CW'(1)) begin
                tmr     <= '0;
                tmr_run <= 1'b0;
            end else begin
                tmr <= tmr - CW'(1);
            end
        end
    end

    // Back-to-back frames restart the window on the same edge the previous one ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q <= 1'b0;
            ocnt <= '0;
        end else if (frm_err) begin
            ov_q <= 1'b0;
            ocnt <= '0;
        end else if (win_start) begin
            ov_q <= 1'b1;
            ocnt <= '0;
        end else if (ov_q) begin
            if (ocnt == LAST) begin
                ov_q <= 1'b0;
                ocnt <= '0;
            end else begin
                ocnt <= ocnt + CW'(1);
            end
        end
    end

    assign sw_sel    = (state == S_FRAME) && (((int'(cnt) / DEPTH) % 2) == 1);
    assign out_valid = ov_q;
    assign out_sop   = ov_q && (ocnt == '0);
    assign out_last  = ov_q && (ocnt == LAST);
    assign bf_en     = ov_q && (((int'(ocnt) / DEPTH) % 2) == 0);
    assign tw_addr   = ov_q ? CW'((int'(ocnt) % DEPTH) * TW_STEP) : '0;
    assign err_gap   = err_q;
    assign busy      = (state == S_FRAME) || tmr_run || ov_q;

endmodule

// File: tb/tb_mdc_stage_ctrl.sv
// Directed bench for mdc_stage_ctrl at DEPTH=4 and DEPTH=16 with a cycle-stamped scoreboard.
module tb_mdc_stage_ctrl;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_sop = 1'b0;

    logic sw4, ov4, os4, ol4, bf4, err4, busy4;
    logic [CW-1:0] tw4;
    logic sw16, ov16, os16, ol16, bf16, err16, busy16;
    logic [CW-1:0] tw16;

    mdc_stage_ctrl #(.DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
        .sw_sel(sw4), .out_valid(ov4), .out_sop(os4), .out_last(ol4),
        .bf_en(bf4), .tw_addr(tw4), .err_gap(err4), .busy(busy4)
    );

    mdc_stage_ctrl #(.DEPTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
        .sw_sel(sw16), .out_valid(ov16), .out_sop(os16), .out_last(ol16),
        .bf_en(bf16), .tw_addr(tw16), .err_gap(err16), .busy(busy16)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit sel16 = 1'b0;
    int dep = 4;

    typedef struct {
        int cyc;
        int ocnt;
    } wexp_t;

    wexp_t wq[$];
    int    swq[$];
    int    errq[$];
    int    bfrom = 0;
    int    buntil = -1;
    bit    in_frame = 1'b0;
    int    idx = 0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s cyc=%0d D=%0d: observed %0h expected %0h", tag, cyc, dep, obs, expv);
        end
    endtask

    task automatic clear_model();
        wq.delete();
        swq.delete();
        errq.delete();
        in_frame = 1'b0;
        idx = 0;
        bfrom = 0;
        buntil = -1;
    endtask

    task automatic accept(input int c);
        if (!(c > bfrom && c <= buntil)) bfrom = c;
        buntil = c + dep + FRAME - 1;
        for (int k = 0; k < FRAME; k++) wq.push_back('{cyc: c + dep + k, ocnt: k});
    endtask

    task automatic frame_err(input int c);
        errq.push_back(c + 1);
        while (wq.size() > 0 && wq[$].cyc > c) void'(wq.pop_back());
        buntil = c;
    endtask

    task automatic model(input bit v, input bit s);
        if (rst_n) begin
            if (!in_frame) begin
                if (v && s) begin
                    accept(cyc);
                    in_frame = 1'b1;
                    idx = 1;
                end
            end else begin
                if (((idx / dep) % 2) == 1) swq.push_back(cyc);
                if (!v || s) begin
                    frame_err(cyc);
                    in_frame = 1'b0;
                    idx = 0;
                end else begin
                    idx++;
                    if (idx == FRAME) begin
                        in_frame = 1'b0;
                        idx = 0;
                    end
                end
            end
        end
    endtask

    task automatic sample();
        logic e_ov, e_sw, e_err, e_busy;
        int oc;
        e_ov = 1'b0;
        oc = 0;
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
            e_ov = 1'b1;
            oc = wq[0].ocnt;
            void'(wq.pop_front());
        end
        e_sw = 1'b0;
        if (swq.size() > 0 && swq[0] == cyc) begin
            e_sw = 1'b1;
            void'(swq.pop_front());
        end
        e_err = 1'b0;
        if (errq.size() > 0 && errq[0] == cyc) begin
            e_err = 1'b1;
            void'(errq.pop_front());
        end
        e_busy = (cyc > bfrom) && (cyc <= buntil);
        chk("out_valid", sel16 ? ov16 : ov4, e_ov);
        chk("out_sop", sel16 ? os16 : os4, e_ov && oc == 0);
        chk("out_last", sel16 ? ol16 : ol4, e_ov && oc == FRAME - 1);
        chk("bf_en", sel16 ? bf16 : bf4, e_ov && ((oc / dep) % 2) == 0);
        chk("tw_addr", sel16 ? tw16 : tw4, e_ov ? (oc % dep) * (FRAME / dep) : 0);
        chk("sw_sel", sel16 ? sw16 : sw4, e_sw);
        chk("err_gap", sel16 ? err16 : err4, e_err);
        chk("busy", sel16 ? busy16 : busy4, e_busy);
    endtask

    task automatic tick(input bit v, input bit s);
        @(negedge clk);
        in_valid = v;
        in_sop = s;
        model(v, s);
        sample();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic send_frame();
        tick(1'b1, 1'b1);
        for (int i = 1; i < FRAME; i++) tick(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sop = 1'b0;
        clear_model();
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        sample();
    endtask

    initial begin
        // reset held: a sop during reset must be ignored
        idle(2);
        tick(1'b1, 1'b1);
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        sample();
        idle(5);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        idle(3);

        // DEPTH=4 single frame
        send_frame();
        idle(8);

        // DEPTH=4 back-to-back frames
        send_frame();
        send_frame();
        idle(8);

        // gap at idx 7, then clean frame 5 cycles after the gap
        tick(1'b1, 1'b1);
        for (int i = 1; i < 7; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        idle(4);
        send_frame();
        idle(8);

        // premature sop at idx 5, trailing valids without sop ignored
        tick(1'b1, 1'b1);
        for (int i = 1; i < 5; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
        idle(2);
        send_frame();
        idle(8);

        // async reset in the middle of a window
        tick(1'b1, 1'b1);
        for (int i = 1; i <= 10; i++) tick(1'b1, 1'b0);
        rst_n = 1'b0;
        clear_model();
        #1;
        sample();
        for (int i = 0; i < 2; i++) tick(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        sample();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        idle(3);
        send_frame();
        idle(8);

        // DEPTH=16
        sel16 = 1'b1;
        dep = 16;
        do_reset();
        idle(2);
        send_frame();
        idle(20);
        send_frame();
        send_frame();
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
